seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cnt_i  input  8  binary count from upstream sequence counter.
REQ-005 SHALL have port: of_i  input  1  upstream overflow flag.
REQ-006 SHALL have port: seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port: an_o  output  3  digit enables {hundreds,tens,units}, active-low one-hot, registered.
REQ-008 SHALL have port: bcd_valid_o  output  1  one-cycle pulse when display registers update.

Function
REQ-009 SHALL run a converter FSM with states LOAD -> SHIFT (exactly 8 cycles) -> UPDATE -> LOAD, free-running, period 10 cycles.
REQ-010 In LOAD: SHALL capture cnt_i and of_i, clear the 12-bit BCD accumulator and the 3-bit shift counter.
REQ-011 In each SHIFT cycle: SHALL add 3 to every BCD nibble >= 5, then shift {BCD, binary} left one bit (double-dabble).
REQ-012 In UPDATE: SHALL copy hundreds/tens/units and captured overflow into display registers and assert bcd_valid_o for exactly that cycle.
REQ-013 Latency: value captured in LOAD at cycle k SHALL be visible in display registers from cycle k+10.
REQ-014 Display registers SHALL hold between UPDATEs; cnt_i changes during SHIFT SHALL NOT affect the conversion in progress.
REQ-015 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, digit index SHALL advance units -> tens -> hundreds -> units.
REQ-016 an_o SHALL be 3'b110 for units, 3'b101 for tens, 3'b011 for hundreds, registered from the digit index.
REQ-017 seg_o SHALL encode digits (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank=7F; dash=3F.
REQ-018 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens both 0; units always shown.
REQ-019 When the displayed overflow flag is 1, all three digits SHALL show dash (3F), blanking ignored.
REQ-020 seg_o/an_o SHALL change only together on the same edge; no cycle with two digits enabled.

Reset
REQ-021 While rst is 1 at a clock edge: FSM -> LOAD, BCD/shift counter/display registers/overflow -> 0, refresh counter -> 0, digit index -> units.
REQ-022 Reset values: seg_o=7F, an_o=3'b111, bcd_valid_o=0.
REQ-023 First edge after rst deasserts SHALL drive an_o=3'b110, seg_o=40 (display "  0").
REQ-024 rst asserted mid-SHIFT SHALL abort conversion; no bcd_valid_o pulse for it; restart from LOAD after release.

Verification (REFRESH_DIV=4)
REQ-025 Reset, cnt_i=0, of_i=0 -> scan units 40, tens 7F, hundreds 7F; an_o sequence 110,101,011 every 4 cycles.
REQ-026 cnt_i=255 held -> within 10 cycles display units 12, tens 12, hundreds 24; bcd_valid_o every 10th cycle.
REQ-027 cnt_i=7 -> units 78, tens 7F, hundreds 7F; cnt_i=105 -> units 12, tens 40, hundreds 79.
REQ-028 of_i=1 with cnt_i=255 -> all digits 3F after next UPDATE; of_i=0 restores numeric display after next UPDATE.
REQ-029 cnt_i changed 3->200 during SHIFT -> next UPDATE shows 3, following UPDATE shows 200.
REQ-030 rst pulsed at SHIFT cycle 4 -> next edge seg_o=7F, an_o=111, bcd_valid_o=0; after release display "  0" until new UPDATE.

Source files
------------

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Converts an 8-bit binary count into three BCD digits with a free-running
// double-dabble FSM (LOAD -> 8x SHIFT -> UPDATE, 10-cycle period), then
// time-multiplexes the digits onto a common 7-segment bus.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   cnt_i[7:0]   binary value to display
//   of_i         overflow flag; shows "---" when captured as 1
//   seg_o[6:0]   segments {g,f,e,d,c,b,a}, active-low, registered
//   an_o[2:0]    digit enables {hundreds,tens,units}, active-low, registered
//   bcd_valid_o  high for the single UPDATE cycle of each conversion
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt_i,
  input  logic       of_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o,
  output logic       bcd_valid_o
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Double-dabble correction: any nibble >= 5 gets +3 so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

  // Active-low segment pattern for a decimal digit; non-decimal codes blank.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Converter state
  state_t      state_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  shcnt_q;
  logic        ovf_cap_q;
  logic        bcd_valid_q;

  // Display registers
  logic [3:0]  disp_h_q, disp_t_q, disp_u_q;
  logic        disp_ovf_q;

  // Scan state
  logic [RW-1:0] refresh_q;
  logic [1:0]    dig_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [19:0] shift_d;
  logic [11:0] bcd_d;
  logic [7:0]  bin_d;

  // --- Stage: double-dabble step (adjust then shift {BCD, binary}) ---
  always_comb begin
    shift_d = {dabble_adj(bcd_q), bin_q} << 1;
    bcd_d   = shift_d[19:8];
    bin_d   = shift_d[7:0];
  end

  // --- Stage: converter FSM and display registers ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      bin_q       <= '0;
      bcd_q       <= '0;
      shcnt_q     <= '0;
      ovf_cap_q   <= 1'b0;
      bcd_valid_q <= 1'b0;
      disp_h_q    <= '0;
      disp_t_q    <= '0;
      disp_u_q    <= '0;
      disp_ovf_q  <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          bin_q     <= cnt_i;
          ovf_cap_q <= of_i;
          bcd_q     <= '0;
          shcnt_q   <= '0;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          shcnt_q <= shcnt_q + 3'd1;
          // Eighth shift: the pulse is raised here so it is high exactly
          // during the UPDATE cycle, when the display registers load.
          if (shcnt_q == 3'd7) begin
            state_q     <= S_UPDATE;
            bcd_valid_q <= 1'b1;
          end
        end
        S_UPDATE: begin
          disp_h_q   <= bcd_q[11:8];
          disp_t_q   <= bcd_q[7:4];
          disp_u_q   <= bcd_q[3:0];
          disp_ovf_q <= ovf_cap_q;
          state_q    <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // --- Stage: digit select and segment decode ---
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 3'b111;
    case (dig_q)
      DIG_UNITS: begin
        an_d  = 3'b110;
        seg_d = seg_enc(disp_u_q);
      end
      DIG_TENS: begin
        an_d  = 3'b101;
        seg_d = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? SEG_BLANK : seg_enc(disp_t_q);
      end
      DIG_HUNDREDS: begin
        an_d  = 3'b011;
        seg_d = (disp_h_q == 4'd0) ? SEG_BLANK : seg_enc(disp_h_q);
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
      end
    endcase
    if (disp_ovf_q && an_d != 3'b111) seg_d = SEG_DASH;
  end

  // --- Stage: refresh timer and registered segment/anode outputs ---
  // seg and an are registered from the same digit index on the same edge,
  // so they always switch together and only one anode is ever active.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      dig_q     <= DIG_UNITS;
      seg_q     <= SEG_BLANK;
      an_q      <= 3'b111;
    end else begin
      if (refresh_q == REF_LAST) begin
        refresh_q <= '0;
        dig_q     <= (dig_q == DIG_HUNDREDS) ? DIG_UNITS : dig_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o       = seg_q;
  assign an_o        = an_q;
  assign bcd_valid_o = bcd_valid_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt_i;
  logic       of_i;
  logic [6:0] seg_o;
  logic [2:0] an_o;
  logic       bcd_valid_o;

  int n_chk  = 0;
  int n_pass = 0;

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_i       (cnt_i),
    .of_i        (of_i),
    .seg_o       (seg_o),
    .an_o        (an_o),
    .bcd_valid_o (bcd_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance until an_o shows the requested digit (bounded), then check it.
  task automatic wait_an(input string tag, input logic [2:0] a);
    int n = 0;
    while (an_o !== a && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_an"}, {5'b0, an_o}, {5'b0, a});
  endtask

  // Advance at least one cycle until bcd_valid_o is seen (bounded).
  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bcd_valid_o !== 1'b1 && n < 20);
    chk({tag, "_valid"}, {7'b0, bcd_valid_o}, 8'h01);
  endtask

  // Full scan: check each digit's pattern once.
  task automatic show_check(input string tag, input logic [6:0] u, input logic [6:0] t,
                            input logic [6:0] h);
    wait_an({tag, "_u"}, 3'b110);
    chk({tag, "_u_seg"}, {1'b0, seg_o}, {1'b0, u});
    wait_an({tag, "_t"}, 3'b101);
    chk({tag, "_t_seg"}, {1'b0, seg_o}, {1'b0, t});
    wait_an({tag, "_h"}, 3'b011);
    chk({tag, "_h_seg"}, {1'b0, seg_o}, {1'b0, h});
  endtask

  // Check whichever digit is currently lit.
  task automatic check_now(input string tag, input logic [6:0] u, input logic [6:0] t,
                           input logic [6:0] h);
    logic [6:0] e;
    if (an_o === 3'b110) e = u;
    else if (an_o === 3'b101) e = t;
    else e = h;
    chk(tag, {1'b0, seg_o}, {1'b0, e});
  endtask

  initial begin
    int n;
    int pulses;
    rst   = 1'b1;
    cnt_i = 8'd0;
    of_i  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_seg", {1'b0, seg_o}, 8'h7F);
    chk("rst_an", {5'b0, an_o}, 8'h07);
    chk("rst_valid", {7'b0, bcd_valid_o}, 8'h00);

    // First edges after release: "  0", scan every 4 cycles, first pulse at cycle 9
    rst = 1'b0;
    tick();
    chk("e1_an", {5'b0, an_o}, 8'h06);
    chk("e1_seg", {1'b0, seg_o}, 8'h40);
    chk("e1_valid", {7'b0, bcd_valid_o}, 8'h00);
    tick(); tick(); tick(); tick();
    chk("e5_an", {5'b0, an_o}, 8'h05);
    chk("e5_seg", {1'b0, seg_o}, 8'h7F);
    tick(); tick(); tick(); tick();
    chk("e9_an", {5'b0, an_o}, 8'h03);
    chk("e9_seg", {1'b0, seg_o}, 8'h7F);
    chk("e9_valid", {7'b0, bcd_valid_o}, 8'h01);
    tick();
    chk("e10_valid", {7'b0, bcd_valid_o}, 8'h00);

    // 255 -> "255", pulse period 10
    cnt_i = 8'd255;
    wait_valid("c255");
    n = 0;
    do begin
      tick();
      n++;
    end while (bcd_valid_o !== 1'b1 && n < 20);
    chk("period", 8'(n), 8'd10);
    tick(); tick();
    show_check("c255", 7'h12, 7'h12, 7'h24);

    // 7 -> "  7"
    cnt_i = 8'd7;
    wait_valid("c7a"); wait_valid("c7b");
    tick(); tick();
    show_check("c7", 7'h78, 7'h7F, 7'h7F);

    // 105 -> "105" (tens zero shown because hundreds non-zero)
    cnt_i = 8'd105;
    wait_valid("c105a"); wait_valid("c105b");
    tick(); tick();
    show_check("c105", 7'h12, 7'h40, 7'h79);

    // Overflow: dashes, then restore
    cnt_i = 8'd255;
    of_i  = 1'b1;
    wait_valid("ofa"); wait_valid("ofb");
    tick(); tick();
    show_check("of1", 7'h3F, 7'h3F, 7'h3F);
    of_i = 1'b0;
    wait_valid("of0a"); wait_valid("of0b");
    tick(); tick();
    show_check("of0", 7'h12, 7'h12, 7'h24);

    // Input change during SHIFT does not disturb the conversion in progress
    cnt_i = 8'd3;
    wait_valid("mid3");
    tick(); tick(); tick();
    cnt_i = 8'd200;
    wait_valid("mid3u");
    tick(); tick();
    check_now("mid_show3", 7'h30, 7'h7F, 7'h7F);
    wait_valid("mid200u");
    tick(); tick();
    check_now("mid_show200", 7'h40, 7'h40, 7'h24);

    // Reset at SHIFT cycle 4
    wait_valid("rsa");
    tick(); tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_seg", {1'b0, seg_o}, 8'h7F);
    chk("mrst_an", {5'b0, an_o}, 8'h07);
    chk("mrst_valid", {7'b0, bcd_valid_o}, 8'h00);
    rst = 1'b0;
    tick();
    chk("mrst_e1_an", {5'b0, an_o}, 8'h06);
    chk("mrst_e1_seg", {1'b0, seg_o}, 8'h40);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bcd_valid_o === 1'b1) pulses++;
    end
    tick();
    if (bcd_valid_o === 1'b1) pulses++;
    chk("mrst_e5_an", {5'b0, an_o}, 8'h05);
    chk("mrst_e5_seg", {1'b0, seg_o}, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bcd_valid_o === 1'b1) pulses++;
    end
    chk("mrst_no_pulse", 8'(pulses), 8'd0);
    tick();
    chk("mrst_e9_valid", {7'b0, bcd_valid_o}, 8'h01);
    chk("mrst_e9_seg", {1'b0, seg_o}, 8'h7F);
    tick(); tick();
    show_check("mrst200", 7'h40, 7'h40, 7'h24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
